clk_div_bank: RTL and testbench

- Parametrised, runtime-reconfigurable bank of integer clock dividers in a single input clock domain.
- Serves as a fabric-level successor to the fixed-configuration clock manager primitive wrapper. Adds per-output divide, duty and phase control, a DRP-style register port, a commit/realign sequence, power-down and a lock indicator.
- Generates NUM_OUT registered divided waveforms or strobes for the baseband datapath.

---
 rtl/clk_div_bank.sv | 244 ++++++++++++++++++++++++
 tb/tb_clk_div_bank.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_bank.sv
// rtl/clk_div_bank.sv - runtime-reconfigurable bank of integer clock dividers with register port
module clk_div_bank #(
    parameter int NUM_OUT     = 4,
    parameter int CNT_W       = 8,
    parameter int LOCK_CYCLES = 16,
    parameter int DIV_DEFAULT = 2
) (
    input  logic               CLKIN,
    input  logic               RST_N,
    input  logic               PWRDWN,
    input  logic               DEN,
    input  logic               DWE,
    input  logic [5:0]         DADDR,
    input  logic [CNT_W-1:0]   DI,
    output logic [CNT_W-1:0]   DO,
    output logic               DRDY,
    output logic [NUM_OUT-1:0] CLKOUT,
    output logic               LOCKED
);

    localparam int HIGH_DEFAULT = (DIV_DEFAULT / 2 < 1) ? 1 : DIV_DEFAULT / 2;
    localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
    localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_CYCLES);
    localparam logic [CNT_W-1:0]  DIV_RST  = CNT_W'(DIV_DEFAULT);
    localparam logic [CNT_W-1:0]  HIGH_RST = CNT_W'(HIGH_DEFAULT);

    localparam logic [1:0] FLD_DIV   = 2'd0;
    localparam logic [1:0] FLD_HIGH  = 2'd1;
    localparam logic [1:0] FLD_PHASE = 2'd2;
    localparam logic [1:0] FLD_CTRL  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t state_q, state_d;

    // register-port pipeline: one stage between accept and completion
    logic             stg_v_q, stg_v_d;
    logic             stg_we_q, stg_we_d;
    logic [5:0]       stg_addr_q, stg_addr_d;
    logic [CNT_W-1:0] stg_di_q, stg_di_d;
    logic             drdy_q, drdy_d;
    logic [CNT_W-1:0] do_q, do_d;
    logic             commit_q, commit_d;

    // shadow (written by the port) and active (used by the dividers) settings
    logic [CNT_W-1:0] div_s_q [NUM_OUT];
    logic [CNT_W-1:0] div_s_d [NUM_OUT];
    logic [CNT_W-1:0] high_s_q [NUM_OUT];
    logic [CNT_W-1:0] high_s_d [NUM_OUT];
    logic [CNT_W-1:0] phase_s_q [NUM_OUT];
    logic [CNT_W-1:0] phase_s_d [NUM_OUT];
    logic [CNT_W-1:0] div_a_q [NUM_OUT];
    logic [CNT_W-1:0] div_a_d [NUM_OUT];
    logic [CNT_W-1:0] high_a_q [NUM_OUT];
    logic [CNT_W-1:0] high_a_d [NUM_OUT];
    logic [CNT_W-1:0] phase_a_q [NUM_OUT];
    logic [CNT_W-1:0] phase_a_d [NUM_OUT];

    // per-channel phase delay, period counter and registered output
    logic [CNT_W-1:0]   dly_q [NUM_OUT];
    logic [CNT_W-1:0]   dly_d [NUM_OUT];
    logic [CNT_W-1:0]   cnt_q [NUM_OUT];
    logic [CNT_W-1:0]   cnt_d [NUM_OUT];
    logic [NUM_OUT-1:0] clk_q, clk_d;

    logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic              locked_q, locked_d;

    logic       accept;
    logic [3:0] stg_ch;
    logic [1:0] stg_fld;
    logic       all_dly_zero;
    logic       align_entry;

    assign DO     = do_q;
    assign DRDY   = drdy_q;
    assign CLKOUT = clk_q;
    assign LOCKED = locked_q;

    // register port: accept when idle, execute the access one cycle later with DRDY
    always_comb begin
        accept     = DEN & ~(stg_v_q | drdy_q);
        stg_ch     = stg_addr_q[5:2];
        stg_fld    = stg_addr_q[1:0];
        stg_v_d    = accept;
        stg_we_d   = stg_we_q;
        stg_addr_d = stg_addr_q;
        stg_di_d   = stg_di_q;
        drdy_d     = 1'b0;
        do_d       = '0;
        commit_d   = 1'b0;
        div_s_d    = div_s_q;
        high_s_d   = high_s_q;
        phase_s_d  = phase_s_q;
        div_a_d    = div_a_q;
        high_a_d   = high_a_q;
        phase_a_d  = phase_a_q;
        if (accept) begin
            stg_we_d   = DWE;
            stg_addr_d = DADDR;
            stg_di_d   = DI;
        end
        if (stg_v_q) begin
            drdy_d = 1'b1;
            for (int i = 0; i < NUM_OUT; i++) begin
                if (stg_ch == 4'(i)) begin
                    if (stg_we_q) begin
                        case (stg_fld)
                            FLD_DIV:   div_s_d[i]   = stg_di_q;
                            FLD_HIGH:  high_s_d[i]  = stg_di_q;
                            FLD_PHASE: phase_s_d[i] = stg_di_q;
                            default:   commit_d     = stg_di_q[0];
                        endcase
                    end else begin
                        case (stg_fld)
                            FLD_DIV:   do_d = div_s_q[i];
                            FLD_HIGH:  do_d = high_s_q[i];
                            FLD_PHASE: do_d = phase_s_q[i];
                            FLD_CTRL:  do_d = CNT_W'({locked_q, state_q});
                            default:   do_d = '0;
                        endcase
                    end
                end
            end
            if (commit_d) begin
                div_a_d   = div_s_q;
                high_a_d  = high_s_q;
                phase_a_d = phase_s_q;
            end
        end
    end

    // sequencing: power-down dominates, commit realigns, ALIGN waits for all phase delays
    always_comb begin
        all_dly_zero = 1'b1;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (dly_q[i] != '0) all_dly_zero = 1'b0;
        end
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = ST_ALIGN;
            ST_ALIGN: if (commit_q) state_d = ST_ALIGN;
                      else if (all_dly_zero) state_d = ST_RUN;
            ST_RUN:   if (commit_q) state_d = ST_ALIGN;
            default:  state_d = ST_IDLE;
        endcase
        if (PWRDWN) state_d = ST_IDLE;
        align_entry = (state_d == ST_ALIGN) && ((state_q == ST_IDLE) || commit_q);

        lock_cnt_d = lock_cnt_q;
        if (state_d != ST_RUN) begin
            lock_cnt_d = '0;
        end else if ((state_q == ST_RUN) && (lock_cnt_q < LOCK_MAX)) begin
            lock_cnt_d = lock_cnt_q + 1'b1;
        end
        locked_d = (state_d == ST_RUN) && (lock_cnt_d >= LOCK_MAX);
    end

    // per-channel divider: hold low through the phase delay, then count 0..d-1
    always_comb begin
        logic [CNT_W-1:0] d_eff;
        d_eff = '0;
        dly_d = dly_q;
        cnt_d = cnt_q;
        clk_d = clk_q;
        for (int i = 0; i < NUM_OUT; i++) begin
            d_eff = (div_a_q[i] == '0) ? CNT_W'(1) : div_a_q[i];
            if (state_d == ST_IDLE) begin
                dly_d[i] = '0;
                cnt_d[i] = '0;
                clk_d[i] = 1'b0;
            end else if (align_entry) begin
                dly_d[i] = phase_a_q[i];
                cnt_d[i] = '0;
                clk_d[i] = 1'b0;
            end else if (dly_q[i] != '0) begin
                dly_d[i] = dly_q[i] - 1'b1;
                clk_d[i] = 1'b0;
            end else begin
                clk_d[i] = (cnt_q[i] < high_a_q[i]);
                cnt_d[i] = (cnt_q[i] >= d_eff - CNT_W'(1)) ? '0 : cnt_q[i] + 1'b1;
            end
        end
    end

    // FSM, lock and register-port state
    always_ff @(posedge CLKIN or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
            stg_v_q    <= 1'b0;
            stg_we_q   <= 1'b0;
            stg_addr_q <= '0;
            stg_di_q   <= '0;
            drdy_q     <= 1'b0;
            do_q       <= '0;
            commit_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
            stg_v_q    <= stg_v_d;
            stg_we_q   <= stg_we_d;
            stg_addr_q <= stg_addr_d;
            stg_di_q   <= stg_di_d;
            drdy_q     <= drdy_d;
            do_q       <= do_d;
            commit_q   <= commit_d;
        end
    end

    // settings and channel counters
    always_ff @(posedge CLKIN or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                div_s_q[i]   <= DIV_RST;
                high_s_q[i]  <= HIGH_RST;
                phase_s_q[i] <= '0;
                div_a_q[i]   <= DIV_RST;
                high_a_q[i]  <= HIGH_RST;
                phase_a_q[i] <= '0;
                dly_q[i]     <= '0;
                cnt_q[i]     <= '0;
            end
            clk_q <= '0;
        end else begin
            div_s_q   <= div_s_d;
            high_s_q  <= high_s_d;
            phase_s_q <= phase_s_d;
            div_a_q   <= div_a_d;
            high_a_q  <= high_a_d;
            phase_a_q <= phase_a_d;
            dly_q     <= dly_d;
            cnt_q     <= cnt_d;
            clk_q     <= clk_d;
        end
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// tb/tb_clk_div_bank.sv - scoreboard bench for clk_div_bank against a timestamp reference model
module tb_clk_div_bank;

    localparam int NUM_OUT     = 4;
    localparam int CNT_W       = 8;
    localparam int LOCK_CYCLES = 16;
    localparam int DIV_DEFAULT = 2;
    localparam int HIGH_DEF    = (DIV_DEFAULT / 2 < 1) ? 1 : DIV_DEFAULT / 2;

    logic               CLKIN  = 1'b0;
    logic               RST_N  = 1'b1;
    logic               PWRDWN = 1'b0;
    logic               DEN    = 1'b0;
    logic               DWE    = 1'b0;
    logic [5:0]         DADDR  = '0;
    logic [CNT_W-1:0]   DI     = '0;
    logic [CNT_W-1:0]   DO;
    logic               DRDY;
    logic [NUM_OUT-1:0] CLKOUT;
    logic               LOCKED;

    clk_div_bank #(
        .NUM_OUT(NUM_OUT), .CNT_W(CNT_W), .LOCK_CYCLES(LOCK_CYCLES), .DIV_DEFAULT(DIV_DEFAULT)
    ) dut (
        .CLKIN(CLKIN), .RST_N(RST_N), .PWRDWN(PWRDWN), .DEN(DEN), .DWE(DWE),
        .DADDR(DADDR), .DI(DI), .DO(DO), .DRDY(DRDY), .CLKOUT(CLKOUT), .LOCKED(LOCKED)
    );

    always #5 CLKIN = ~CLKIN;

    typedef struct { int cyc; int data; } rd_t;
    typedef struct { logic [NUM_OUT-1:0] clk; logic lk; } out_t;

    rd_t  sbq[$];
    out_t outq[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // reference model: settings as integers, alignment as a timestamp
    int m_div_s [NUM_OUT];
    int m_high_s [NUM_OUT];
    int m_phase_s [NUM_OUT];
    int m_div_a [NUM_OUT];
    int m_high_a [NUM_OUT];
    int m_phase_a [NUM_OUT];
    bit m_idle = 1'b1;
    int m_align_t = 0;
    bit m_stg_v = 1'b0;
    bit m_stg_we;
    int m_stg_ch, m_stg_fld, m_stg_di;
    int m_drdy_cyc = -10;
    bit m_commit_pend = 1'b0;
    int prev_state = 0;
    bit prev_locked = 1'b0;

    bit   commit_now, busy, do_copy;
    int   rdata, st;
    out_t ne;
    out_t oe;
    rd_t  re;
    bit   have;

    function automatic void model_expect(input int c, output logic [NUM_OUT-1:0] clk, output logic lk, output int state);
        int maxp, rs, k, d;
        clk = '0;
        lk = 1'b0;
        state = 0;
        if (!m_idle) begin
            maxp = 0;
            for (int i = 0; i < NUM_OUT; i++) if (m_phase_a[i] > maxp) maxp = m_phase_a[i];
            rs = m_align_t + maxp + 1;
            state = (c < rs) ? 1 : 2;
            lk = (c >= rs + LOCK_CYCLES);
            for (int i = 0; i < NUM_OUT; i++) begin
                d = (m_div_a[i] == 0) ? 1 : m_div_a[i];
                k = c - (m_align_t + m_phase_a[i]);
                clk[i] = (k >= 1) && (((k - 1) % d) < m_high_a[i]);
            end
        end
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_OUT; i++) begin
            m_div_s[i] = DIV_DEFAULT; m_high_s[i] = HIGH_DEF; m_phase_s[i] = 0;
            m_div_a[i] = DIV_DEFAULT; m_high_a[i] = HIGH_DEF; m_phase_a[i] = 0;
        end
        m_idle = 1'b1;
        m_stg_v = 1'b0;
        m_drdy_cyc = -10;
        m_commit_pend = 1'b0;
        prev_state = 0;
        prev_locked = 1'b0;
        sbq.delete();
    endtask

    // model step: inputs sampled at the edge produce the expected outputs of the next cycle
    always @(posedge CLKIN) begin
        if (!RST_N) begin
            model_reset();
            ne.clk = '0;
            ne.lk = 1'b0;
            outq.push_back(ne);
        end else begin
            commit_now = m_commit_pend;
            m_commit_pend = 1'b0;
            do_copy = 1'b0;
            busy = m_stg_v || (m_drdy_cyc == cyc);
            if (m_stg_v) begin
                rdata = 0;
                if (m_stg_ch < NUM_OUT) begin
                    if (m_stg_we) begin
                        case (m_stg_fld)
                            0: m_div_s[m_stg_ch] = m_stg_di;
                            1: m_high_s[m_stg_ch] = m_stg_di;
                            2: m_phase_s[m_stg_ch] = m_stg_di;
                            default: if (m_stg_di % 2 == 1) begin do_copy = 1'b1; m_commit_pend = 1'b1; end
                        endcase
                    end else begin
                        case (m_stg_fld)
                            0: rdata = m_div_s[m_stg_ch];
                            1: rdata = m_high_s[m_stg_ch];
                            2: rdata = m_phase_s[m_stg_ch];
                            default: rdata = (prev_locked ? 4 : 0) + prev_state;
                        endcase
                    end
                end
                sbq.push_back('{cyc + 1, rdata});
                m_drdy_cyc = cyc + 1;
                m_stg_v = 1'b0;
            end
            if (DEN && !busy) begin
                m_stg_v = 1'b1;
                m_stg_we = DWE;
                m_stg_ch = int'(DADDR[5:2]);
                m_stg_fld = int'(DADDR[1:0]);
                m_stg_di = int'(DI);
            end
            if (PWRDWN) m_idle = 1'b1;
            else if (m_idle || commit_now) begin
                m_idle = 1'b0;
                m_align_t = cyc + 1;
            end
            model_expect(cyc + 1, ne.clk, ne.lk, st);
            outq.push_back(ne);
            prev_state = st;
            prev_locked = ne.lk;
            if (do_copy) begin
                m_div_a = m_div_s;
                m_high_a = m_high_s;
                m_phase_a = m_phase_s;
            end
        end
        cyc++;
    end

    // monitor: compare outputs each cycle and every DRDY against the scoreboard
    always @(negedge CLKIN) begin
        if (cyc > 0) begin
            have = 1'b0;
            if (outq.size() > 0) begin
                oe = outq.pop_front();
                have = 1'b1;
            end
            if (!RST_N) begin
                checks++;
                if (CLKOUT !== '0 || LOCKED !== 1'b0 || DRDY !== 1'b0 || DO !== '0) begin
                    errors++;
                    $display("FAIL reset_state cyc=%0d got clk=%b lk=%b drdy=%b do=%0d want all zero", cyc, CLKOUT, LOCKED, DRDY, DO);
                end
            end else begin
                if (have) begin
                    checks++;
                    if (CLKOUT !== oe.clk || LOCKED !== oe.lk) begin
                        errors++;
                        $display("FAIL clk_lock cyc=%0d got clk=%b lk=%b want clk=%b lk=%b", cyc, CLKOUT, LOCKED, oe.clk, oe.lk);
                    end
                end
                while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL drdy_missing cyc=%0d got no drdy want drdy at cyc=%0d", cyc, sbq[0].cyc);
                    void'(sbq.pop_front());
                end
                if (DRDY === 1'b1) begin
                    checks++;
                    if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
                        re = sbq.pop_front();
                        if (DO !== CNT_W'(re.data)) begin
                            errors++;
                            $display("FAIL read_data cyc=%0d got do=%0d want do=%0d", cyc, DO, re.data);
                        end
                    end else begin
                        errors++;
                        $display("FAIL drdy_unexpected cyc=%0d got drdy=1 want drdy=0", cyc);
                    end
                end else if (DRDY !== 1'b0) begin
                    checks++;
                    errors++;
                    $display("FAIL drdy_x cyc=%0d got drdy=%b want 0/1", cyc, DRDY);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLKIN);
            #1;
        end
    endtask

    task automatic reg_acc(input bit we, input int ch, input int fld, input int di);
        DEN = 1'b1;
        DWE = we;
        DADDR = {ch[3:0], fld[1:0]};
        DI = CNT_W'(di);
        tick(1);
        DEN = 1'b0;
        DWE = 1'b0;
        tick(3);
    endtask

    task automatic commit();
        reg_acc(1'b1, 0, 3, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d got no finish want finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N = 1'b0;
        tick(3);
        RST_N = 1'b1;
        tick(40);

        // reconfigure ch1 with a phase offset, ch0 phase 0
        reg_acc(1'b1, 1, 0, 5);
        reg_acc(1'b1, 1, 1, 2);
        reg_acc(1'b1, 1, 2, 3);
        reg_acc(1'b1, 0, 2, 0);
        commit();
        tick(40);

        // degenerate settings
        reg_acc(1'b1, 2, 1, 0);
        reg_acc(1'b1, 3, 0, 0);
        reg_acc(1'b1, 3, 1, 1);
        commit();
        tick(30);
        reg_acc(1'b1, 2, 1, 9);
        reg_acc(1'b1, 2, 0, 4);
        commit();
        tick(30);

        // back-to-back DEN: the second is ignored
        DEN = 1'b1; DWE = 1'b0; DADDR = {4'd1, 2'd0};
        tick(1);
        DADDR = {4'd2, 2'd0};
        tick(1);
        DEN = 1'b0;
        tick(4);

        // shadow readback before commit, out-of-range channel, control field
        reg_acc(1'b1, 0, 0, 7);
        reg_acc(1'b0, 0, 0, 0);
        tick(10);
        reg_acc(1'b0, 15, 0, 0);
        reg_acc(1'b0, 15, 1, 0);
        reg_acc(1'b1, 9, 0, 3);
        reg_acc(1'b0, 9, 0, 0);
        reg_acc(1'b0, 0, 3, 0);
        reg_acc(1'b1, 0, 3, 0);
        tick(10);

        // power-down in RUN, commit while powered down, release
        PWRDWN = 1'b1;
        tick(5);
        reg_acc(1'b1, 0, 0, 3);
        commit();
        reg_acc(1'b0, 0, 3, 0);
        PWRDWN = 1'b0;
        tick(30);

        // commit whose realign cycle coincides with power-down
        reg_acc(1'b1, 1, 2, 1);
        DEN = 1'b1; DWE = 1'b1; DADDR = {4'd0, 2'd3}; DI = 8'd1;
        tick(1);
        DEN = 1'b0; DWE = 1'b0;
        tick(1);
        PWRDWN = 1'b1;
        tick(3);
        PWRDWN = 1'b0;
        tick(25);

        // reset mid-access and mid-period
        DEN = 1'b1; DWE = 1'b1; DADDR = {4'd1, 2'd0}; DI = 8'd6;
        tick(1);
        DEN = 1'b0; DWE = 1'b0;
        RST_N = 1'b0;
        tick(2);
        RST_N = 1'b1;
        tick(20);
        reg_acc(1'b0, 1, 0, 0);

        // randomized traffic
        repeat (30) begin
            case ($urandom_range(0, 5))
                0, 1, 2: begin
                    int f;
                    f = $urandom_range(0, 2);
                    reg_acc(1'b1, $urandom_range(0, NUM_OUT), f,
                            (f == 0) ? $urandom_range(0, 7) : (f == 1) ? $urandom_range(0, 8) : $urandom_range(0, 4));
                end
                3: begin
                    commit();
                    tick($urandom_range(5, 30));
                end
                4: begin
                    repeat (8) begin
                        DEN = 1'($urandom_range(0, 1));
                        DWE = 1'($urandom_range(0, 1));
                        DADDR = 6'($urandom);
                        DI = CNT_W'($urandom_range(0, 6));
                        tick(1);
                    end
                    DEN = 1'b0;
                    DWE = 1'b0;
                    tick(3);
                end
                default: begin
                    PWRDWN = 1'b1;
                    tick($urandom_range(1, 4));
                    PWRDWN = 1'b0;
                    tick(10);
                end
            endcase
        end
        commit();
        tick(LOCK_CYCLES + 30);

        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drdy_pending got %0d outstanding want 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
